cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the multi-cycle MIPS core.
- Accepts the core's instruction-fetch channel and data-memory channel, which are both valid/ready, and serialises them onto one shared memory port.
- Holds at most one outstanding transaction and buffers each read response in a one-entry register before returning it to the requesting channel.
- Provides four event counters that feed the core's performance-counter outputs.

Parameters:
DATA_FIRST, 1, 1: a data request wins over a simultaneous instruction request; 0: the instruction request wins.
CNT_W, 32, width of each event counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
PC  in  32  instruction fetch address
Inst_Req_Valid  in  1  fetch request valid
Inst_Req_Ready  out  1  fetch request accepted
Instruction  out  32  fetched word
Inst_Valid  out  1  fetched word valid
Inst_Ready  in  1  core takes fetched word
Address  in  32  data address
MemWrite  in  1  store request
MemRead  in  1  load request
Write_data  in  32  store data
Write_strb  in  4  store byte enables
Mem_Req_Ready  out  1  data request accepted
Read_data  out  32  load word
Read_data_Valid  out  1  load word valid
Read_data_Ready  in  1  core takes load word
mem_req_valid  out  1  shared-port request valid
mem_req_ready  in  1  shared-port request accepted
mem_addr  out  32  word-aligned address
mem_wen  out  1  1 = write, 0 = read
mem_wdata  out  32  write data
mem_wstrb  out  4  byte enables (4'b0000 on reads)
mem_rdata  in  32  read data
mem_rvalid  in  1  read data valid
mem_rready  out  1  arbiter takes read data
cnt_inst  out  CNT_W  completed fetches
cnt_load  out  CNT_W  completed loads
cnt_store  out  CNT_W  completed stores
cnt_busy  out  CNT_W  cycles spent outside IDLE

Behaviour:
- States: IDLE, I_REQ, I_WAIT, I_RESP, D_REQ, D_WAIT, D_RESP, W_REQ. Encoding is one-hot.
- Reset (rst=0, asynchronous):
  - state returns to IDLE.
  - All outputs are 0, all counters are 0, and the address, data, strobe and response buffer registers are 0.
  - A transaction in progress is discarded; nothing is replayed after reset.
- IDLE, request acceptance:
  - Mem_Req_Ready = MemRead|MemWrite when DATA_FIRST=1, and = (MemRead|MemWrite) & ~Inst_Req_Valid when DATA_FIRST=0.
  - Inst_Req_Ready = Inst_Req_Valid & ~Mem_Req_Ready.
  - Both ready signals are combinational and are 0 in every state other than IDLE.
- On acceptance, the request is latched:
  - addr_reg <= {addr[31:2], 2'b00}; on a store, wdata/strb are also latched.
  - Transitions: fetch -> I_REQ; MemWrite -> W_REQ (MemWrite takes precedence if MemWrite and MemRead are both high); MemRead only -> D_REQ.
- I_REQ, D_REQ and W_REQ:
  - mem_req_valid = 1; mem_addr, mem_wen, mem_wdata and mem_wstrb come only from registers and stay stable until mem_req_ready.
  - On mem_req_ready: I_REQ -> I_WAIT, D_REQ -> D_WAIT, W_REQ -> IDLE with cnt_store += 1.
- I_WAIT and D_WAIT:
  - mem_rready = 1.
  - On mem_rvalid: rbuf <= mem_rdata, then I_WAIT -> I_RESP or D_WAIT -> D_RESP.
  - If mem_rvalid arrives in a *_REQ state, it is ignored (mem_rready = 0 there).
- I_RESP and D_RESP:
  - Assert Inst_Valid or Read_data_Valid respectively; Instruction and Read_data = rbuf.
  - When the core's ready is high: go to IDLE and increment cnt_inst or cnt_load.
  - Instruction and Read_data hold rbuf in all states.
- Latency with zero-wait memory (mem_req_ready=1, mem_rvalid one cycle after the request handshake), with acceptance at cycle 0:
  - Read: mem_req_valid at cycle 1, mem_rvalid at cycle 2, valid to the core at cycle 3, and a new acceptance is possible at cycle 4 at the earliest.
  - Store: completes at cycle 1.
- cnt_busy increments on every cycle in which state != IDLE.
- Counters:
  - All counters wrap modulo 2^CNT_W without saturating.
  - A counter increments at most once per cycle.

Test Plan:
- Fetch, zero-wait memory: PC=0x00000004, Inst_Req_Valid=1, mem_rdata=0x24080005 -> mem_addr=0x00000004 with mem_wen=0 at cycle 1; Instruction=0x24080005 with Inst_Valid=1 at cycle 3; cnt_inst=1; cnt_busy=3.
- Collision with DATA_FIRST=1: Inst_Req_Valid=1 and MemRead=1 (Address=0x1002) in the same cycle -> Mem_Req_Ready=1, Inst_Req_Ready=0; mem_addr=0x1000; the fetch is served only after Read_data_Valid and Read_data_Ready complete.
- Store: Address=0x203, MemWrite=1, Write_data=0xAABBCCDD, Write_strb=4'b1000, mem_req_ready held 0 for 3 cycles -> mem_req_valid=1 with all fields stable for 4 cycles; mem_wstrb=4'b1000; no read response; cnt_store=1.
- Backpressure: mem_rvalid with rdata=0x12345678 while Read_data_Ready=0 for 5 cycles -> Read_data_Valid held 1 with Read_data stable at 0x12345678; mem_rready=0; Mem_Req_Ready=0 throughout.
- Reset mid-operation: drive rst=0 during D_WAIT -> all outputs 0 immediately without a clock edge; after release, state is IDLE, counters are 0, and a late mem_rvalid is ignored.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Serialises the core's fetch and data channels onto one shared memory port.
// One transaction in flight; read data returns through a one-entry buffer.
module cpu_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  // instruction fetch channel
  input  logic [31:0]      PC,
  input  logic             Inst_Req_Valid,
  output logic             Inst_Req_Ready,
  output logic [31:0]      Instruction,
  output logic             Inst_Valid,
  input  logic             Inst_Ready,
  // data channel
  input  logic [31:0]      Address,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      Write_data,
  input  logic [3:0]       Write_strb,
  output logic             Mem_Req_Ready,
  output logic [31:0]      Read_data,
  output logic             Read_data_Valid,
  input  logic             Read_data_Ready,
  // shared memory port
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_wen,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             mem_rready,
  // event counters
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and request fields hold until the transfer.

  typedef enum logic [7:0] {
    IDLE   = 8'b0000_0001,
    I_REQ  = 8'b0000_0010,
    I_WAIT = 8'b0000_0100,
    I_RESP = 8'b0000_1000,
    D_REQ  = 8'b0001_0000,
    D_WAIT = 8'b0010_0000,
    D_RESP = 8'b0100_0000,
    W_REQ  = 8'b1000_0000
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  strb_reg;
  logic [31:0] rbuf;
  logic        data_req;
  logic        idle_ok;

  always_comb begin
    state_nxt       = state;
    data_req        = MemRead | MemWrite;
    // Gated by reset so the readies read 0 while reset is held.
    idle_ok         = (state == IDLE) && rst;
    Mem_Req_Ready   = idle_ok && data_req && (DATA_FIRST || !Inst_Req_Valid);
    Inst_Req_Ready  = idle_ok && Inst_Req_Valid && !Mem_Req_Ready;
    mem_req_valid   = 1'b0;
    mem_wen         = 1'b0;
    mem_rready      = 1'b0;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    mem_addr        = addr_reg;
    mem_wdata       = wdata_reg;
    mem_wstrb       = 4'b0000;
    Instruction     = rbuf;
    Read_data       = rbuf;

    unique case (state)
      IDLE: begin
        if (Mem_Req_Ready)       state_nxt = MemWrite ? W_REQ : D_REQ;
        else if (Inst_Req_Ready) state_nxt = I_REQ;
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = I_WAIT;
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = D_WAIT;
      end
      W_REQ: begin
        mem_req_valid = 1'b1;
        mem_wen       = 1'b1;
        mem_wstrb     = strb_reg;
        if (mem_req_ready) state_nxt = IDLE;
      end
      I_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_nxt = I_RESP;
      end
      D_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_nxt = D_RESP;
      end
      I_RESP: begin
        Inst_Valid = 1'b1;
        if (Inst_Ready) state_nxt = IDLE;
      end
      D_RESP: begin
        Read_data_Valid = 1'b1;
        if (Read_data_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      rbuf      <= '0;
      cnt_inst  <= '0;
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_busy  <= '0;
    end else begin
      state <= state_nxt;
      if (Mem_Req_Ready) begin
        addr_reg <= Address & ~32'd3;
        if (MemWrite) begin
          wdata_reg <= Write_data;
          strb_reg  <= Write_strb;
        end
      end else if (Inst_Req_Ready) begin
        addr_reg <= PC & ~32'd3;
      end
      if (mem_rready && mem_rvalid) rbuf <= mem_rdata;
      if (state != IDLE) cnt_busy <= cnt_busy + CNT_W'(1);
      if (state == W_REQ && mem_req_ready) cnt_store <= cnt_store + CNT_W'(1);
      if (state == I_RESP && Inst_Ready) cnt_inst <= cnt_inst + CNT_W'(1);
      if (state == D_RESP && Read_data_Ready) cnt_load <= cnt_load + CNT_W'(1);
    end
  end

endmodule
